// File: rtl/pio_edge_irq_pkg.sv
// Shared state encoding and PIO register byte offsets for pio_edge_irq_master.
package pio_edge_irq_pkg;

  typedef enum logic [2:0] {
    StInitWr,
    StIdle,
    StRdCap,
    StWaitCap,
    StWrClr,
    StRdData,
    StWaitData,
    StEmit
  } pio_state_e;

  localparam logic [31:0] OffsData = 32'd0;
  localparam logic [31:0] OffsMask = 32'd8;
  localparam logic [31:0] OffsCap  = 32'd12;

endpackage

// File: rtl/pio_edge_irq_master.sv
// Hardware service loop for an edge-capture PIO: program irqmask once, then on each interrupt
// read and clear edgecapture, read data, and hand both values out on a valid/ready stream.
module pio_edge_irq_master
  import pio_edge_irq_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned       DATA_W        = 32,
  parameter logic [DATA_W-1:0] IRQ_MASK_INIT = DATA_W'(1),
  parameter int unsigned       TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              irq_in,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_capture,
  output logic [DATA_W-1:0] evt_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        spurious_cnt
);

  pio_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              evt_valid_q, evt_valid_d;
  logic              err_q, err_d;
  logic [7:0]        spur_q, spur_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              tmo_hit, tmo_fire;

  // Counter equals cycles already spent in the wait state, so this is the TIMEOUT-th one.
  assign tmo_hit = (tmo_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cap_d       = cap_q;
    data_d      = data_q;
    evt_valid_d = evt_valid_q;
    spur_d      = spur_q;
    tmo_fire    = 1'b0;

    unique case (state_q)
      StInitWr: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = BASE_ADDR + OffsMask;
          wdata_d = IRQ_MASK_INIT;
        end else if (!avm_waitrequest) begin
          write_d = 1'b0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (irq_in && enable) begin
          read_d  = 1'b1;
          addr_d  = BASE_ADDR + OffsCap;
          state_d = StRdCap;
        end
      end
      StRdCap: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = StWaitCap;
        end
      end
      StWaitCap: begin
        if (avm_readdatavalid) begin
          cap_d   = avm_readdata;
          write_d = 1'b1;
          addr_d  = BASE_ADDR + OffsCap;
          wdata_d = '0;
          state_d = StWrClr;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      StWrClr: begin
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          if (cap_q == '0) begin
            if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
            state_d = StIdle;
          end else begin
            read_d  = 1'b1;
            addr_d  = BASE_ADDR + OffsData;
            state_d = StRdData;
          end
        end
      end
      StRdData: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (avm_readdatavalid) begin
          data_d      = avm_readdata;
          evt_valid_d = 1'b1;
          state_d     = StEmit;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      StEmit: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tmo_d = '0;
    if (state_d == state_q && (state_q == StWaitCap || state_q == StWaitData)) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // A fresh timeout wins over the enable-low clear.
  assign err_d = tmo_fire | (err_q & enable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInitWr;
      addr_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cap_q       <= '0;
      data_q      <= '0;
      evt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      spur_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
      evt_valid_q <= evt_valid_d;
      err_q       <= err_d;
      spur_q      <= spur_d;
      tmo_q       <= tmo_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign evt_valid     = evt_valid_q;
  assign evt_capture   = cap_q;
  assign evt_data      = data_q;
  assign busy          = (state_q != StIdle);
  assign err_timeout   = err_q;
  assign spurious_cnt  = spur_q;

endmodule

// File: tb/tb_pio_edge_irq_master.sv
// Bench for pio_edge_irq_master: behavioural PIO slave, transaction-level reference model
// checked every cycle, plus directed latency, stall, spurious, timeout and reset cases.
module tb_pio_edge_irq_master;

  localparam int unsigned DW        = 32;
  localparam int unsigned TMO       = 4;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] MASK_INIT = 32'h1;
  localparam logic [31:0] A_DATA    = BASE + 32'd0;
  localparam logic [31:0] A_MASK    = BASE + 32'd8;
  localparam logic [31:0] A_CAP     = BASE + 32'd12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          irq_in;
  logic [31:0]   avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          rdv, wr;
  logic          evt_valid, evt_ready;
  logic [DW-1:0] evt_capture, evt_data;
  logic          busy, err_timeout;
  logic [7:0]    spurious_cnt;

  pio_edge_irq_master #(
    .BASE_ADDR    (BASE),
    .DATA_W       (DW),
    .IRQ_MASK_INIT(MASK_INIT),
    .TIMEOUT      (TMO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .irq_in           (irq_in),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(rdv),
    .avm_waitrequest  (wr),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_capture      (evt_capture),
    .evt_data         (evt_data),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .spurious_cnt     (spurious_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    check_eq(name, {31'b0, cond}, 32'h1);
  endtask

  // Slave knobs, written only by the main process.
  logic        irq_man, auto_en, stall_rand, withhold;
  logic [31:0] cap_inject, data_val;
  int          stall_cfg, lat_max;

  // Slave state, written only by the slave process.
  logic [31:0] cap_reg, pend_val;
  bit          pend;
  int          pend_dly, stall_cnt;

  assign irq_in = irq_man | (auto_en & (cap_reg != 32'h0));

  initial begin : slave
    cap_reg = '0; pend = 0; pend_dly = 0; pend_val = '0; stall_cnt = 0;
    wr = 1'b0; rdv = 1'b0; avm_readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        pend = 0; rdv = 1'b0; wr = 1'b0; stall_cnt = 0; cap_reg = '0; avm_readdata = '0;
      end else begin
        rdv = 1'b0;
        if (pend) begin
          if (withhold) pend = 0;
          else begin
            pend_dly--;
            if (pend_dly == 0) begin
              rdv = 1'b1; avm_readdata = pend_val; pend = 0;
            end
          end
        end
        cap_reg = cap_reg | cap_inject;
        if (stall_rand) wr = ($urandom_range(0, 3) == 0);
        else if (avm_read || avm_write) begin
          if (stall_cnt < stall_cfg) begin wr = 1'b1; stall_cnt++; end
          else begin wr = 1'b0; stall_cnt = 0; end
        end else wr = 1'b0;
        if (avm_write && !wr && avm_address == A_CAP) cap_reg = '0;
        if (avm_read && !wr) begin
          pend     = 1;
          pend_dly = int'($urandom_range(1, lat_max));
          pend_val = (avm_address == A_CAP) ? cap_reg : data_val;
        end
      end
    end
  end

  // Reference model: expected bus commands and events as queues built from the returned data.
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wd;} cmd_t;
  typedef struct packed {logic [31:0] cap; logic [31:0] dat;} evt_t;

  cmd_t        exp_cmd[$];
  evt_t        exp_evt[$];
  cmd_t        c_cmd;
  evt_t        c_evt;
  logic [31:0] m_cap, m_rd_addr;
  int          m_spur, m_wait;
  bit          m_err, m_out, m_busy, m_busy_nx, fire, trig;
  bit          p_stall, p_hold, p_trig;
  logic        p_rd, p_wr;
  logic [31:0] p_addr, p_wd, p_cap, p_dat;
  int          n_evt = 0;
  int          n_data_rd = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check_eq("rst_flags", {27'b0, busy, avm_read, avm_write, evt_valid, err_timeout},
                 32'h10);
        check_eq("rst_zero", avm_address | avm_writedata | evt_capture | evt_data |
                 32'(spurious_cnt), 32'h0);
        exp_cmd.delete(); exp_evt.delete();
        c_cmd.we = 1'b1; c_cmd.addr = A_MASK; c_cmd.wd = MASK_INIT;
        exp_cmd.push_back(c_cmd);
        m_spur = 0; m_err = 0; m_out = 0; m_wait = 0; m_busy = 1; m_cap = '0;
        p_stall = 0; p_hold = 0; p_trig = 0; p_rd = 0; p_wr = 0;
        p_addr = '0; p_wd = '0; p_cap = '0; p_dat = '0;
      end else begin
        check_eq("spurious_cnt", 32'(spurious_cnt), 32'(m_spur));
        check_eq("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
        check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
        if (p_stall)
          check_true("cmd_stable", avm_read === p_rd && avm_write === p_wr &&
                     avm_address === p_addr && avm_writedata === p_wd);
        if (p_hold)
          check_true("evt_hold", evt_valid && evt_capture === p_cap && evt_data === p_dat);
        if (p_trig) check_true("start_after_irq", avm_read && avm_address === A_CAP);
        if (avm_read && !p_rd && exp_cmd.size() == 0) check_true("start_justified", p_trig);

        m_busy_nx = m_busy;
        trig = !m_busy && irq_in && enable;
        if (trig) m_busy_nx = 1;

        fire = 0;
        if (m_out) begin
          if (rdv) begin
            m_out = 0;
            if (m_rd_addr == A_CAP) begin
              m_cap = avm_readdata;
              c_cmd.we = 1'b1; c_cmd.addr = A_CAP; c_cmd.wd = '0;
              exp_cmd.push_back(c_cmd);
            end else begin
              c_evt.cap = m_cap; c_evt.dat = avm_readdata;
              exp_evt.push_back(c_evt);
            end
          end else begin
            m_wait++;
            if (m_wait == int'(TMO)) begin
              fire = 1; m_out = 0; exp_cmd.delete(); m_busy_nx = 0;
            end
          end
        end

        if ((avm_read || avm_write) && !wr) begin
          check_true("single_cmd", !(avm_read && avm_write));
          if (exp_cmd.size() == 0) begin
            check_true("unexpected_cmd", avm_read && avm_address == A_CAP);
          end else begin
            c_cmd = exp_cmd.pop_front();
            check_eq("cmd_kind", {31'b0, avm_write}, {31'b0, c_cmd.we});
            check_eq("cmd_addr", avm_address, c_cmd.addr);
            if (c_cmd.we) check_eq("cmd_wdata", avm_writedata, c_cmd.wd);
          end
          if (avm_read) begin
            check_true("one_outstanding", !m_out);
            m_out = 1; m_wait = 0; m_rd_addr = avm_address;
            if (avm_address == A_DATA) n_data_rd++;
          end
          if (avm_write && avm_address == A_MASK) m_busy_nx = 0;
          if (avm_write && avm_address == A_CAP) begin
            if (m_cap == 32'h0) begin
              if (m_spur < 255) m_spur++;
              m_busy_nx = 0;
            end else begin
              c_cmd.we = 1'b0; c_cmd.addr = A_DATA; c_cmd.wd = '0;
              exp_cmd.push_back(c_cmd);
            end
          end
        end

        if (evt_valid && evt_ready) begin
          check_true("evt_expected", exp_evt.size() != 0);
          if (exp_evt.size() != 0) begin
            c_evt = exp_evt.pop_front();
            check_eq("evt_capture", evt_capture, c_evt.cap);
            check_eq("evt_data", evt_data, c_evt.dat);
          end
          n_evt++;
          m_busy_nx = 0;
        end

        m_err   = fire | (m_err & enable);
        p_trig  = trig;
        m_busy  = m_busy_nx;
        p_stall = (avm_read || avm_write) && wr;
        p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_wd = avm_writedata;
        p_hold = evt_valid && !evt_ready; p_cap = evt_capture; p_dat = evt_data;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Pulse irq for one cycle with an optional capture edge; return cycles until evt_valid.
  task automatic irq_pulse_latency(input logic [31:0] cap, input logic [31:0] dat, output int n);
    irq_man = 1'b1; cap_inject = cap; data_val = dat;
    cyc();
    irq_man = 1'b0; cap_inject = '0; n = 1;
    while (!evt_valid && n < 60) begin cyc(); n++; end
  endtask

  int n, ndr;
  bit ev;

  initial begin : main
    reset_n = 1'b0; enable = 1'b1; evt_ready = 1'b0;
    irq_man = 1'b0; auto_en = 1'b0; stall_rand = 1'b0; withhold = 1'b0;
    cap_inject = '0; data_val = '0; stall_cfg = 0; lat_max = 1;
    cyc(3);
    check_eq("rst_busy", {31'b0, busy}, 32'h1);
    check_eq("rst_write", {31'b0, avm_write}, 32'h0);

    // Reset release: single mask write, then idle.
    reset_n = 1'b1;
    cyc();
    check_eq("init_write", {31'b0, avm_write}, 32'h1);
    check_eq("init_addr", avm_address, 32'h8);
    check_eq("init_wdata", avm_writedata, 32'h1);
    cyc();
    check_eq("init_busy_low", {31'b0, busy}, 32'h0);
    check_eq("init_write_low", {31'b0, avm_write}, 32'h0);

    // Minimum latency.
    irq_pulse_latency(32'h1, 32'h1, n);
    check_eq("lat_min", 32'(n), 32'd6);
    check_eq("lat_min_cap", evt_capture, 32'h1);
    check_eq("lat_min_data", evt_data, 32'h1);
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0; cyc(2);

    // Three stall cycles on each of the three commands.
    stall_cfg = 3;
    irq_pulse_latency(32'h2, 32'hABCD, n);
    check_eq("lat_stall", 32'(n), 32'd15);
    check_eq("stall_cap", evt_capture, 32'h2);
    check_eq("stall_data", evt_data, 32'hABCD);
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0; stall_cfg = 0; cyc(2);

    // Spurious interrupt: capture reads zero.
    ndr = n_data_rd; ev = 0;
    irq_man = 1'b1; cyc(); irq_man = 1'b0;
    repeat (10) begin cyc(); if (evt_valid) ev = 1; end
    check_eq("spur_cnt", 32'(spurious_cnt), 32'd1);
    check_eq("spur_no_evt", {31'b0, ev}, 32'h0);
    check_eq("spur_no_data_rd", 32'(n_data_rd), 32'(ndr));

    // Timeout in the capture wait, then clear by dropping enable.
    withhold = 1'b1;
    irq_man = 1'b1; cyc(); irq_man = 1'b0; n = 1;
    while (!err_timeout && n < 40) begin cyc(); n++; end
    check_eq("tmo_cycles", 32'(n), 32'd6);
    check_eq("tmo_idle", {31'b0, busy}, 32'h0);
    withhold = 1'b0;
    cyc(2);
    check_eq("tmo_sticky", {31'b0, err_timeout}, 32'h1);
    enable = 1'b0; cyc();
    check_eq("tmo_cleared", {31'b0, err_timeout}, 32'h0);
    enable = 1'b1; cyc();

    // Backpressure with irq held high, then back-to-back restart.
    irq_man = 1'b1; cap_inject = 32'h4; data_val = 32'h55;
    cyc(); cap_inject = '0; n = 1;
    while (!evt_valid && n < 40) begin cyc(); n++; end
    check_true("bp_valid_seen", evt_valid);
    cyc(10);
    check_eq("bp_valid_held", {31'b0, evt_valid}, 32'h1);
    check_eq("bp_cap_held", evt_capture, 32'h4);
    check_eq("bp_data_held", evt_data, 32'h55);
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
    check_eq("b2b_idle_cycle", {30'b0, busy, avm_read}, 32'h0);
    cyc();
    check_eq("b2b_read", {31'b0, avm_read}, 32'h1);
    check_eq("b2b_addr", avm_address, 32'hC);
    irq_man = 1'b0; cyc(10);
    check_eq("b2b_spur", 32'(spurious_cnt), 32'd2);

    // Randomised traffic.
    auto_en = 1'b1; stall_rand = 1'b1; lat_max = 3;
    repeat (3000) begin
      cap_inject = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFF) : 32'h0;
      data_val   = $urandom;
      irq_man    = ($urandom_range(0, 31) == 0);
      evt_ready  = ($urandom_range(0, 1) == 1);
      enable     = ($urandom_range(0, 15) != 0);
      cyc();
    end
    auto_en = 1'b0; irq_man = 1'b0; cap_inject = '0; evt_ready = 1'b1; enable = 1'b1;
    stall_rand = 1'b0; lat_max = 1;
    cyc(30);
    check_eq("drain_evt_q", 32'(exp_evt.size()), 32'h0);
    check_eq("drain_idle", {31'b0, busy}, 32'h0);
    check_true("rand_events", n_evt >= 20);

    // Asynchronous reset in the middle of a sequence.
    evt_ready = 1'b0;
    irq_man = 1'b1; cap_inject = 32'h8; cyc();
    irq_man = 1'b0; cap_inject = '0; cyc(2);
    reset_n = 1'b0; #1;
    check_eq("mid_rst_flags", {27'b0, busy, avm_read, avm_write, evt_valid, err_timeout},
             32'h10);
    check_eq("mid_rst_spur", 32'(spurious_cnt), 32'h0);
    cyc(2);
    reset_n = 1'b1; cyc();
    check_eq("rerun_init_write", {31'b0, avm_write}, 32'h1);
    check_eq("rerun_init_addr", avm_address, 32'h8);
    cyc(3);
    check_eq("rerun_idle", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pio_edge_irq_master.md
# pio_edge_irq_master

Avalon-MM master that services an edge-capture PIO slave in hardware, with no Nios II involvement. After reset it programs the slave's interrupt mask. On each slave interrupt it reads the edge-capture register, clears it, reads the data register, and delivers both values as one event on a valid/ready stream. It sits between a GUI input PIO (e.g. a paint/touch line) and a fabric consumer that cannot wait for software interrupt latency.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base address of the PIO slave.
- DATA_W, 32: Avalon data width.
- IRQ_MASK_INIT, 32'h1: value written to the irqmask register after reset.
- TIMEOUT, 255: maximum wait in cycles for `readdatavalid`, range 1..65535.

- clk  in  1: clock.
- reset_n  in  1: reset, asynchronous, active-low.
- enable  in  1: service enable. When low, no new transaction starts.
- irq_in  in  1: slave interrupt, level, synchronous to clk.
- avm_address  out  32: byte address.
- avm_read  out  1: read command.
- avm_write  out  1: write command.
- avm_writedata  out  DATA_W: write data.
- avm_readdata  in  DATA_W: read data.
- avm_readdatavalid  in  1: read data qualifier.
- avm_waitrequest  in  1: slave stall.
- evt_valid  out  1: event available.
- evt_ready  in  1: consumer accepts the event.
- evt_capture  out  DATA_W: edge-capture snapshot.
- evt_data  out  DATA_W: data register snapshot.
- busy  out  1: FSM not in IDLE.
- err_timeout  out  1: sticky timeout flag. Cleared when `enable` is low.
- spurious_cnt  out  8: count of captures read as zero. Saturates at 255.

## Operation
- Register map, byte addresses: data at BASE_ADDR+0, irqmask at BASE_ADDR+8, edgecapture at BASE_ADDR+12.
- FSM states: INIT_WR, IDLE, RD_CAP, WAIT_CAP, WR_CLR, RD_DATA, WAIT_DATA, EMIT.
- INIT_WR: entered on reset release. Writes IRQ_MASK_INIT to irqmask, then goes to IDLE. This happens once per reset.
- IDLE: if `irq_in && enable`, go to RD_CAP.
- RD_CAP: issue a read of edgecapture. Go to WAIT_CAP once the command is accepted.
- WAIT_CAP: on `readdatavalid`, latch `evt_capture` and go to WR_CLR.
- WR_CLR: write 0 to edgecapture.
  - If the latched capture is 0, increment `spurious_cnt` and go to IDLE.
  - Otherwise go to RD_DATA.
- RD_DATA: issue a read of the data register. Go to WAIT_DATA once accepted.
- WAIT_DATA: on `readdatavalid`, latch `evt_data` and go to EMIT.
- EMIT: hold `evt_valid` until `evt_ready`, then go to IDLE.
- Command acceptance: a command is accepted in the cycle where `read` or `write` is high and `waitrequest` is low. While `waitrequest` is high, address, data and command stay stable.
- Exactly one outstanding read at any time.
- Timeout: a counter runs in WAIT_CAP and WAIT_DATA. When it reaches TIMEOUT, set `err_timeout`, go to IDLE and emit no event. The counter clears on every state entry.
- `enable` falling mid-sequence: the current sequence runs to IDLE (or to timeout) unaltered. Only new starts are gated.
- `irq_in` still high on return to IDLE: the next sequence starts in the following cycle. Edges arriving during servicing are held by the slave and are not lost.
- Backpressure: while in EMIT, `irq_in` is ignored.

## Timing
- Reset values:
  - `avm_read`, `avm_write`, `evt_valid`, `err_timeout`: 0.
  - `avm_address`, `avm_writedata`, `evt_capture`, `evt_data`: 0.
  - `spurious_cnt`: 0.
  - `busy`: 1, since the FSM resets into INIT_WR.
- `avm_write` asserts in the first cycle after `reset_n` rises.
- All Avalon outputs are registered. No combinational path from any input to any output.
- Minimum irq-to-event latency is 6 cycles (IDLE sees irq at cycle 0, `evt_valid` high at cycle 6). This assumes zero waitrequest and readdatavalid one cycle after acceptance, the PIO's fixed latency.
- Back-to-back: the next `avm_read` can assert 1 cycle after the `evt_valid`/`evt_ready` handshake.
- `evt_capture` and `evt_data` are stable while `evt_valid` is high.
- Asynchronous reset mid-sequence: all outputs return to their reset values immediately and the FSM reruns INIT_WR.

## Structure
- Package `pio_edge_irq_pkg` holds:
  - the state enum;
  - register offset localparams: DATA 0, MASK 8, CAP 12.
- No sub-module is required. The timeout counter is inline.

## Test plan
- Reset release with IRQ_MASK_INIT=1 → one write of 0x1 to address 0x8 while `waitrequest`=0. `busy` falls the cycle after acceptance.
- `irq_in` pulse, slave capture=0x1, data=0x1 → reads of 0xC and 0x0, write of 0 to 0xC, `evt_valid` at cycle 6 with capture 0x1 and data 0x1.
- `waitrequest` held high for 3 cycles on each command → commands stay stable, event is still correct, latency is 15 cycles.
- Capture reads 0 → no event, `spurious_cnt` increments to 1, no read of 0x0 is issued.
- `readdatavalid` withheld with TIMEOUT=4 → `err_timeout`=1 after 4 cycles in WAIT_CAP, FSM returns to IDLE. Dropping `enable` clears the flag.
- `evt_ready` low for 10 cycles while `irq_in` stays high → `evt_valid` and data are held. A second sequence starts 1 cycle after the handshake.
